// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready is registered, so no combinational ready path runs stage-to-stage.
module pipe_stage_skid_reg #(
    parameter int PC_W   = 32,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 26,
    parameter int REG_W  = 5,
    parameter int NOP_OP = 55,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [OP_W-1:0]   op_in,
    input  logic [DATA_W-1:0] os_in,
    input  logic [DATA_W-1:0] ot_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] imm_dpl_in,
    input  logic [REG_W-1:0]  wreg_in,
    input  logic [DATA_W-1:0] result_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [OP_W-1:0]   op_out,
    output logic [DATA_W-1:0] os_out,
    output logic [DATA_W-1:0] ot_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] imm_dpl_out,
    output logic [REG_W-1:0]  wreg_out,
    output logic [DATA_W-1:0] result_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [OP_W-1:0]  NOP     = OP_W'(NOP_OP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [OP_W-1:0]   skid_op;
    logic [DATA_W-1:0] skid_os;
    logic [DATA_W-1:0] skid_ot;
    logic [ADDR_W-1:0] skid_addr;
    logic [DATA_W-1:0] skid_imm_dpl;
    logic [REG_W-1:0]  skid_wreg;
    logic [DATA_W-1:0] skid_result;

    logic              acc;
    logic              pop;
    logic [REG_W-1:0]  wreg_cap;

    assign acc      = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    // Bubbles travel as real entries but must never write a register.
    assign wreg_cap = (op_in == NOP) ? '0 : wreg_in;

    // The main entry is the output register set itself; out_valid is its valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            pc_out       <= '0;
            op_out       <= NOP;
            os_out       <= '0;
            ot_out       <= '0;
            addr_out     <= '0;
            imm_dpl_out  <= '0;
            wreg_out     <= '0;
            result_out   <= '0;
            skid_valid   <= 1'b0;
            skid_pc      <= '0;
            skid_op      <= NOP;
            skid_os      <= '0;
            skid_ot      <= '0;
            skid_addr    <= '0;
            skid_imm_dpl <= '0;
            skid_wreg    <= '0;
            skid_result  <= '0;
            in_ready     <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            op_out     <= NOP;
            wreg_out   <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || pop) begin
            if (skid_valid) begin
                out_valid   <= 1'b1;
                pc_out      <= skid_pc;
                op_out      <= skid_op;
                os_out      <= skid_os;
                ot_out      <= skid_ot;
                addr_out    <= skid_addr;
                imm_dpl_out <= skid_imm_dpl;
                wreg_out    <= skid_wreg;
                result_out  <= skid_result;
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end else if (acc) begin
                out_valid   <= 1'b1;
                pc_out      <= pc_in;
                op_out      <= op_in;
                os_out      <= os_in;
                ot_out      <= ot_in;
                addr_out    <= addr_in;
                imm_dpl_out <= imm_dpl_in;
                wreg_out    <= wreg_cap;
                result_out  <= result_in;
            end else if (pop) begin
                out_valid <= 1'b0;
                op_out    <= NOP;
                wreg_out  <= '0;
            end
        end else if (acc) begin
            skid_valid   <= 1'b1;
            skid_pc      <= pc_in;
            skid_op      <= op_in;
            skid_os      <= os_in;
            skid_ot      <= ot_in;
            skid_addr    <= addr_in;
            skid_imm_dpl <= imm_dpl_in;
            skid_wreg    <= wreg_cap;
            skid_result  <= result_in;
            in_ready     <= 1'b0;
        end
    end

    // Stall counter is deliberately immune to flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed execute/writeback stage register.
- Captures one instruction's stage bundle: pc, op, os, ot, addr, imm_dpl, wreg, result.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and no combinational ready path runs stage-to-stage.
- Adds synchronous flush, bubble (NOP) injection and a saturating backpressure counter.
- Instantiated between any two pipeline stages (E/W, M/W, ...).

Parameters:
- PC_W, 32, pc field width
- OP_W, 6, opcode width
- DATA_W, 32, width of os/ot/imm_dpl/result
- ADDR_W, 26, jump-address field width
- REG_W, 5, destination register index width
- NOP_OP, 55, opcode that marks a bubble
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous: discard all held and incoming entries
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  this stage can accept; registered
- pc_in, op_in, os_in, ot_in, addr_in, imm_dpl_in, wreg_in, result_in  in  per parameter widths  input bundle
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts
- pc_out, op_out, os_out, ot_out, addr_out, imm_dpl_out, wreg_out, result_out  out  per parameter widths  output bundle
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit. All outputs are registered.
- Reset (async, rst=1): main and skid invalid; out_valid=0; op_out=NOP_OP; wreg_out=0; all other outputs 0; in_ready=1; stall_cnt=0. Reset asserted mid-transfer drops everything immediately.
- Handshake events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Capture rule: stored wreg = (op_in==NOP_OP) ? 0 : wreg_in. All other fields are stored verbatim.
- Priority per clock edge: rst > flush > normal operation.
- Flush:
  - Main and skid become invalid; op_out=NOP_OP; wreg_out=0; in_ready=1 next cycle.
  - The bundle presented this cycle is discarded even if in_valid=1.
  - stall_cnt is unaffected.
- Normal operation:
  - Main empty or pop, skid empty, acc: main <= input. Latency in->out is 1 cycle.
  - Main empty or pop, skid full: main <= skid; skid invalid; in_ready=1 next cycle. acc is impossible here because in_ready=0.
  - Main full, no pop, acc: skid <= input; in_ready=0 next cycle.
  - Pop with nothing to refill: main invalid; op_out=NOP_OP; wreg_out=0; other data outputs hold their last value.
  - No event: state holds.
- in_ready = ~skid_valid, registered. An entry accepted while in_ready=1 is never lost, even if out_ready falls the same cycle.
- Bubble inputs: op_in==NOP_OP with in_valid=1 is a real transfer (occupies an entry) but carries wreg=0.
- Ordering: strict FIFO; skid content always leaves before any later input.
- Throughput: 1 bundle/cycle sustained with out_ready=1.
- stall_cnt: +1 on each edge where out_valid=1 and out_ready=0. Holds at 2^CNT_W-1. Cleared only by rst.

Test Plan:
- Reset: assert rst mid-cycle with main and skid full -> immediately out_valid=0, op_out=55, wreg_out=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, 4 back-to-back bundles pc=0x100..0x10C, wreg=3 -> each appears 1 cycle later in order; in_ready stays 1.
- Backpressure: hold out_ready=0 and send pc=0x200, then 0x204 -> main=0x200, skid=0x204, in_ready=0, stall_cnt counts 1,2,3. Release -> 0x200 then 0x204 emitted, in_ready returns 1.
- Bubble: op_in=55, wreg_in=7, in_valid=1 -> out_valid=1, op_out=55, wreg_out=0. Same with op_in=35 -> wreg_out=7.
- Flush: both entries full and in_valid=1 with pc=0x300 -> next cycle out_valid=0, op_out=55, in_ready=1; 0x300 never emitted.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt sticks at 15.
